// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, opcodes,
// instruction classes and the datapath select codes.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JAL    = 4'd9,
    S_JR     = 4'd10,
    S_JUMP   = 4'd11,
    S_ERR    = 4'd15
  } state_t;

  typedef enum logic [3:0] {
    C_MEM_LD, C_MEM_ST, C_ALU_R, C_ALU_I, C_BR, C_JAL, C_JR, C_J, C_ILLEGAL
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_LUI  = 3'b100;

  localparam logic [1:0] SIGN_ZERO = 2'b00;
  localparam logic [1:0] SIGN_EXT  = 2'b01;
  localparam logic [1:0] SIGN_JUMP = 2'b10;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_RS     = 2'b11;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct to instruction class plus
// the ALU controls used while the instruction sits in EXEC.
module mc_decode
  import multicycle_controller_pkg::*;
#(
  parameter int SUPPORT_J = 1
) (
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [3:0] iclass,
  output logic [2:0] exec_alu_op,
  output logic [1:0] exec_srcb,
  output logic [1:0] exec_sign
);

  iclass_t cls;

  always_comb begin
    cls         = C_ILLEGAL;
    exec_alu_op = ALU_ADD;
    exec_srcb   = SRCB_RT;
    exec_sign   = SIGN_ZERO;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls = C_ALU_R;
          FN_SUBU: begin
            cls         = C_ALU_R;
            exec_alu_op = ALU_SUB;
          end
          FN_JR:   cls = C_JR;
          default: cls = C_ILLEGAL;
        endcase
      end
      OP_LW:  cls = C_MEM_LD;
      OP_SW:  cls = C_MEM_ST;
      OP_ORI: begin
        cls         = C_ALU_I;
        exec_srcb   = SRCB_IMM;
        exec_alu_op = ALU_OR;
      end
      OP_LUI: begin
        cls         = C_ALU_I;
        exec_srcb   = SRCB_IMM;
        exec_alu_op = ALU_LUI;
      end
      OP_BEQ: cls = C_BR;
      OP_JAL: cls = C_JAL;
      OP_J:   cls = (SUPPORT_J != 0) ? C_J : C_ILLEGAL;
      default: cls = C_ILLEGAL;
    endcase
  end

  assign iclass = cls;

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences each instruction over 3-5 cycles,
// waits on mem_ready with an optional timeout, and drives datapath enables.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int SUPPORT_J  = 1,
  parameter int TIMEOUT_W  = 4,
  parameter int TIMEOUT_EN = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Option,
  input  logic [5:0] Function,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] Sign,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_instr,
  output logic       bus_err
);

  localparam logic [TIMEOUT_W-1:0] CNT_ONES = '1;
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = CNT_ONES - 1'b1;

  state_t               cur, nxt;
  logic [TIMEOUT_W-1:0] cnt;
  logic                 bus_err_q;
  logic [3:0]           cls_raw;
  iclass_t              cls;
  logic [2:0]           exec_alu_op;
  logic [1:0]           exec_srcb, exec_sign;
  logic                 wait_st, timeout;
  logic                 pc_wr, pc_cond, mem_wr, ir_wr, reg_wr;

  // The branch decision is taken by the datapath through PCWriteCond.
  logic unused_zero;
  assign unused_zero = Zero;

  mc_decode #(.SUPPORT_J(SUPPORT_J)) u_decode (
    .op          (Option),
    .funct       (Function),
    .iclass      (cls_raw),
    .exec_alu_op (exec_alu_op),
    .exec_srcb   (exec_srcb),
    .exec_sign   (exec_sign)
  );
  assign cls = iclass_t'(cls_raw);

  assign wait_st = (cur == S_FETCH) || (cur == S_MEMRD) || (cur == S_MEMWR);
  assign timeout = (TIMEOUT_EN != 0) && wait_st && !mem_ready && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur <= S_FETCH;
    else        cur <= nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (nxt != cur)                cnt <= '0;
      else if (wait_st && !mem_ready) cnt <= cnt + 1'b1;
      if (timeout) bus_err_q <= 1'b1;
    end
  end

  always_comb begin
    nxt           = cur;
    pc_wr         = 1'b0;
    pc_cond       = 1'b0;
    mem_wr        = 1'b0;
    ir_wr         = 1'b0;
    reg_wr        = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    RegDst        = RD_RT;
    MemtoReg      = M2R_ALU;
    ALUSrcA       = 1'b0;
    ALUSrcB       = SRCB_RT;
    ALUOp         = 3'b000;
    Sign          = SIGN_ZERO;
    PCSource      = PCS_ALU;
    instr_done    = 1'b0;
    illegal_instr = 1'b0;
    case (cur)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        ALUOp   = ALU_ADD;
        ir_wr   = mem_ready;
        pc_wr   = mem_ready;
        if (mem_ready)    nxt = S_DECODE;
        else if (timeout) nxt = S_ERR;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM_SH;
        Sign    = SIGN_EXT;
        ALUOp   = ALU_ADD;
        case (cls)
          C_MEM_LD, C_MEM_ST: nxt = S_MEMADR;
          C_ALU_R, C_ALU_I:   nxt = S_EXEC;
          C_BR:               nxt = S_BRANCH;
          C_JAL:              nxt = S_JAL;
          C_JR:               nxt = S_JR;
          C_J:                nxt = S_JUMP;
          default: begin
            illegal_instr = 1'b1;
            instr_done    = 1'b1;
            nxt           = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        Sign    = SIGN_EXT;
        ALUOp   = ALU_ADD;
        nxt     = (cls == C_MEM_ST) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready)    nxt = S_MEMWB;
        else if (timeout) nxt = S_ERR;
      end
      S_MEMWB: begin
        reg_wr     = 1'b1;
        RegDst     = RD_RT;
        MemtoReg   = M2R_MDR;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_MEMWR: begin
        mem_wr = 1'b1;
        IorD   = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          nxt        = S_FETCH;
        end else if (timeout) begin
          nxt = S_ERR;
        end
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = exec_srcb;
        Sign    = exec_sign;
        ALUOp   = exec_alu_op;
        nxt     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_wr     = 1'b1;
        MemtoReg   = M2R_ALU;
        RegDst     = (cls == C_ALU_R) ? RD_RD : RD_RT;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_RT;
        ALUOp      = ALU_SUB;
        pc_cond    = 1'b1;
        PCSource   = PCS_ALUOUT;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_JAL: begin
        reg_wr     = 1'b1;
        RegDst     = RD_RA;
        MemtoReg   = M2R_PC;
        pc_wr      = 1'b1;
        PCSource   = PCS_JUMP;
        Sign       = SIGN_JUMP;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_JR: begin
        pc_wr      = 1'b1;
        PCSource   = PCS_RS;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_JUMP: begin
        pc_wr      = 1'b1;
        PCSource   = PCS_JUMP;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_ERR:   nxt = S_ERR;
      default: nxt = S_FETCH;
    endcase
  end

  // Write strobes are forced low while reset is held, even though FETCH is Mealy on mem_ready.
  assign PCWrite     = pc_wr & reset;
  assign PCWriteCond = pc_cond & reset;
  assign MemWrite    = mem_wr & reset;
  assign IRWrite     = ir_wr & reset;
  assign RegWrite    = reg_wr & reset;
  assign state       = cur;
  assign bus_err     = bus_err_q;

endmodule
